// File: rtl/irq_arbiter_if.sv
// ============================================================================
// Module      : irq_arbiter_if
// Description : Request/acknowledge bundle between IRQ sources and arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface irq_arbiter_if #(
    parameter int IRQ_SRCS = 8,
    parameter int ID_W     = 3
);
    logic [IRQ_SRCS-1:0] irq_src;
    logic                nmi_src;
    logic                rst_src;
    logic                cfg_we;
    logic [IRQ_SRCS-1:0] cfg_mask;
    logic                irq_ack;
    logic                nmi_ack;
    logic                eoi;
    logic                irq;
    logic                nmi;
    logic                rst;
    logic [ID_W-1:0]     irq_id;
    logic                in_service;
    logic [IRQ_SRCS-1:0] mask;

    modport slave (
        input  irq_src, nmi_src, rst_src, cfg_we, cfg_mask, irq_ack, nmi_ack, eoi,
        output irq, nmi, rst, irq_id, in_service, mask
    );

    modport master (
        output irq_src, nmi_src, rst_src, cfg_we, cfg_mask, irq_ack, nmi_ack, eoi,
        input  irq, nmi, rst, irq_id, in_service, mask
    );
endinterface

`default_nettype wire

// File: rtl/irq_arbiter.sv
// ============================================================================
// Module      : irq_arbiter
// Description : Round-robin IRQ arbiter with edge-triggered NMI and soft reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_arbiter #(
    parameter int IRQ_SRCS = 8,
    parameter int ID_W     = 3
) (
    input  logic          clk,
    input  logic          a_rst,
    irq_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    localparam logic [ID_W:0] N_EXT = (ID_W+1)'(IRQ_SRCS);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_q, rr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [IRQ_SRCS-1:0] mask_q, mask_d;
    logic                nmi_pend_q, nmi_pend_d;
    logic                nmi_src_q;
    logic                rst_q;

    logic [IRQ_SRCS-1:0] cand;
    logic                nmi_edge;
    logic                win_vld;
    logic [ID_W-1:0]     win_id;
    logic [ID_W:0]       scan_idx;
    logic [ID_W:0]       id_inc_ext;
    logic [ID_W-1:0]     id_inc;

    assign cand     = bus.irq_src & mask_q;
    assign nmi_edge = bus.nmi_src & ~nmi_src_q;
    assign mask_d   = bus.cfg_we ? bus.cfg_mask : mask_q;

    // Scan from rr upward, wrapping, and keep the first enabled request.
    always_comb begin
        win_vld  = 1'b0;
        win_id   = '0;
        scan_idx = '0;
        for (int i = 0; i < IRQ_SRCS; i++) begin
            scan_idx = {1'b0, rr_q} + (ID_W+1)'(i);
            if (scan_idx >= N_EXT) begin
                scan_idx = scan_idx - N_EXT;
            end
            if (!win_vld && cand[scan_idx[ID_W-1:0]]) begin
                win_vld = 1'b1;
                win_id  = scan_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        id_inc_ext = {1'b0, id_q} + {{ID_W{1'b0}}, 1'b1};
        id_inc     = (id_inc_ext == N_EXT) ? '0 : id_inc_ext[ID_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        id_d       = id_q;
        nmi_pend_d = nmi_edge | (nmi_pend_q & ~bus.nmi_ack);
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d = ST_REQ;
                    id_d    = win_id;
                end
            end
            ST_REQ: begin
                // Acknowledge beats a simultaneous withdraw.
                if (bus.irq_ack) begin
                    state_d = ST_SERVICE;
                end else if (!cand[id_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (bus.eoi) begin
                    state_d = ST_IDLE;
                    rr_d    = id_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.rst_src) begin
            state_d    = ST_IDLE;
            rr_d       = '0;
            nmi_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state_q    <= ST_IDLE;
            rr_q       <= '0;
            id_q       <= '0;
            mask_q     <= '0;
            nmi_pend_q <= 1'b0;
            nmi_src_q  <= 1'b0;
            rst_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            id_q       <= id_d;
            mask_q     <= mask_d;
            nmi_pend_q <= nmi_pend_d;
            nmi_src_q  <= bus.nmi_src;
            rst_q      <= bus.rst_src;
        end
    end

    assign bus.irq        = (state_q == ST_REQ);
    assign bus.in_service = (state_q == ST_SERVICE);
    assign bus.irq_id     = id_q;
    assign bus.nmi        = nmi_pend_q;
    assign bus.rst        = rst_q;
    assign bus.mask       = mask_q;

endmodule

`default_nettype wire
